// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: candy motor, then coin-by-coin change/refund with ack timeouts.
// Optional VEND_COUNT_EN adds a saturating vend_count output.
module vend_dispense_ctrl #(
   parameter int unsigned COIN_VALUE = 5,
   parameter int unsigned AMT_W      = 6,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [AMT_W-1:0] req_amount,
   output logic             motor_go,
   input  logic             motor_done,
   output logic             coin_eject,
   input  logic             coin_ack,
   output logic             busy,
   output logic             done_pulse,
   output logic             fault,
   input  logic             fault_clr,
`ifdef VEND_COUNT_EN
   output logic [15:0]      vend_count,
`endif
   output logic [2:0]       dbg_state
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_MOTOR      = 3'd1;
   localparam logic [2:0] S_EJECT      = 3'd2;
   localparam logic [2:0] S_EJECT_WAIT = 3'd3;
   localparam logic [2:0] S_DONE       = 3'd4;
   localparam logic [2:0] S_FAULT      = 3'd5;

   localparam logic [1:0] OP_NOP      = 2'b00;
   localparam logic [1:0] OP_REFUND   = 2'b01;
   localparam logic [1:0] OP_VEND     = 2'b10;
   localparam logic [1:0] OP_VEND_CHG = 2'b11;

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
   localparam logic [AMT_W-1:0] COIN   = AMT_W'(COIN_VALUE);

   logic [2:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [TW-1:0]    timer_q, timer_d;

   // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
   // req_ready is high only in IDLE, and op/amount are latched on that edge.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      rem_d   = rem_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               rem_d   = (req_op == OP_REFUND || req_op == OP_VEND_CHG) ? req_amount : '0;
               timer_d = '0;
               case (req_op)
                  OP_VEND, OP_VEND_CHG: state_d = S_MOTOR;
                  OP_REFUND:            state_d = (req_amount != '0) ? S_EJECT : S_DONE;
                  default:              state_d = S_DONE;
               endcase
            end
         end
         S_MOTOR: begin
            if (motor_done) begin
               state_d = (op_q == OP_VEND_CHG && rem_q != '0) ? S_EJECT : S_DONE;
            end else if (timer_q == T_LAST) begin
               state_d = S_FAULT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_EJECT: begin
            timer_d = '0;
            state_d = S_EJECT_WAIT;
         end
         S_EJECT_WAIT: begin
            // A partial coin's worth still costs a whole coin, so saturate at zero.
            if (coin_ack) begin
               rem_d   = (rem_q > COIN) ? rem_q - COIN : '0;
               state_d = (rem_q > COIN) ? S_EJECT : S_DONE;
            end else if (timer_q == T_LAST) begin
               state_d = S_FAULT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_FAULT: begin
            if (fault_clr) begin
               state_d = S_IDLE;
               rem_d   = '0;
               timer_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= OP_NOP;
         rem_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rem_q   <= rem_d;
         timer_q <= timer_d;
      end
   end

`ifdef VEND_COUNT_EN
   logic [15:0] vend_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vend_count_q <= '0;
      end else if (state_q == S_MOTOR && motor_done && vend_count_q != 16'hFFFF) begin
         vend_count_q <= vend_count_q + 16'd1;
      end
   end

   assign vend_count = vend_count_q;
`endif

   assign req_ready  = (state_q == S_IDLE);
   assign motor_go   = (state_q == S_MOTOR);
   assign coin_eject = (state_q == S_EJECT);
   assign done_pulse = (state_q == S_DONE);
   assign fault      = (state_q == S_FAULT);
   assign busy       = (state_q != S_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: vend, change, refund, timeouts, async reset.
module tb_vend_dispense_ctrl;

   localparam int AMT_W = 6;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic [1:0]       req_op = 2'b00;
   logic [AMT_W-1:0] req_amount = '0;
   logic             motor_done = 1'b0;
   logic             fault_clr = 1'b0;
   logic             coin_ack;
   logic             req_ready, motor_go, coin_eject, busy, done_pulse, fault;
   logic [2:0]       dbg_state;
`ifdef VEND_COUNT_EN
   logic [15:0]      vend_count;
`endif

   vend_dispense_ctrl #(.COIN_VALUE(5), .AMT_W(AMT_W), .TIMEOUT(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_amount (req_amount),
      .motor_go   (motor_go),
      .motor_done (motor_done),
      .coin_eject (coin_eject),
      .coin_ack   (coin_ack),
      .busy       (busy),
      .done_pulse (done_pulse),
      .fault      (fault),
      .fault_clr  (fault_clr),
`ifdef VEND_COUNT_EN
      .vend_count (vend_count),
`endif
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int motor_cnt = 0, eject_cnt = 0, done_cnt = 0, ack_cnt = 0;
   logic auto_ack = 1'b1;

   // Level counters sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (motor_go)   motor_cnt++;
      if (coin_eject) eject_cnt++;
      if (done_pulse) done_cnt++;
      if (coin_ack)   ack_cnt++;
   end

   // Ejector model: acks one cycle after each eject pulse.
   initial begin
      logic pend;
      coin_ack = 1'b0;
      pend     = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         coin_ack = auto_ack && pend;
         pend     = coin_eject;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [1:0] op, input logic [AMT_W-1:0] amt);
      req_valid  = 1'b1;
      req_op     = op;
      req_amount = amt;
      tick();
      req_valid  = 1'b0;
   endtask

   // Called right after send(): motor_done is sampled on the n-th edge after accept.
   task automatic run_motor(input int n);
      for (int i = 1; i < n; i++) tick();
      motor_done = 1'b1;
      tick();
      motor_done = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done_pulse && n < budget) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, done_pulse}, 32'd1);
   endtask

   initial begin
      int m0, e0, d0, a0, n;

      // Reset state
      rst_n = 1'b0;
      #12;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_motor_go", {31'd0, motor_go}, 32'd0);
      chk("rst_coin_eject", {31'd0, coin_eject}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done_pulse", {31'd0, done_pulse}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_state", {29'd0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Op 10: motor high 3 cycles, one done, no coins
      m0 = motor_cnt; e0 = eject_cnt; d0 = done_cnt;
      send(2'b10, 6'd0);
      chk("v_busy", {31'd0, busy}, 32'd1);
      chk("v_ready_low", {31'd0, req_ready}, 32'd0);
      chk("v_motor_go", {31'd0, motor_go}, 32'd1);
      run_motor(3);
      chk("v_done_pulse", {31'd0, done_pulse}, 32'd1);
      chk("v_motor_drop", {31'd0, motor_go}, 32'd0);
      tick();
      chk("v_ready_back", {31'd0, req_ready}, 32'd1);
      chk("v_busy_clear", {31'd0, busy}, 32'd0);
      chk("v_motor_cycles", motor_cnt - m0, 32'd3);
      chk("v_ejects", eject_cnt - e0, 32'd0);
      chk("v_dones", done_cnt - d0, 32'd1);

      // Op 11 amount 10: two coins, done after 2nd ack
      e0 = eject_cnt; a0 = ack_cnt; d0 = done_cnt;
      send(2'b11, 6'd10);
      run_motor(2);
      wait_done("vc_done_seen", 40);
      chk("vc_acks_at_done", ack_cnt - a0, 32'd2);
      chk("vc_ejects", eject_cnt - e0, 32'd2);
      tick();
      chk("vc_dones", done_cnt - d0, 32'd1);

      // Op 01 amount 7: ceil(7/5) = 2 coins, no motor
      m0 = motor_cnt; e0 = eject_cnt;
      send(2'b01, 6'd7);
      wait_done("r7_done_seen", 40);
      tick();
      chk("r7_ejects", eject_cnt - e0, 32'd2);
      chk("r7_motor", motor_cnt - m0, 32'd0);

      // Op 01 amount 5: exactly one coin
      e0 = eject_cnt;
      send(2'b01, 6'd5);
      wait_done("r5_done_seen", 40);
      tick();
      chk("r5_ejects", eject_cnt - e0, 32'd1);

      // Op 01 amount 0 and op 00: done_pulse one cycle after accept, no actuators
      m0 = motor_cnt; e0 = eject_cnt;
      send(2'b01, 6'd0);
      chk("r0_done_latency", {31'd0, done_pulse}, 32'd1);
      tick();
      send(2'b00, 6'd9);
      chk("nop_done_latency", {31'd0, done_pulse}, 32'd1);
      tick();
      chk("nop_ready", {31'd0, req_ready}, 32'd1);
      chk("r0_nop_actuators", (motor_cnt - m0) + (eject_cnt - e0), 32'd0);

      // motor_done on the last permitted cycle still wins over the timeout
      send(2'b10, 6'd0);
      run_motor(15);
      chk("edge_done_wins", {31'd0, done_pulse}, 32'd1);
      chk("edge_no_fault", {31'd0, fault}, 32'd0);
      tick();

      // Motor timeout: 15 cycles of motor_go, then sticky fault
      d0 = done_cnt;
      send(2'b10, 6'd0);
      n = 0;
      while (motor_go && n < 40) begin
         tick();
         n++;
      end
      chk("mto_motor_cycles", n, 32'd15);
      chk("mto_fault", {31'd0, fault}, 32'd1);
      chk("mto_motor_off", {31'd0, motor_go}, 32'd0);
      chk("mto_ready_low", {31'd0, req_ready}, 32'd0);
      chk("mto_busy", {31'd0, busy}, 32'd1);
      tick(); tick();
      chk("mto_sticky", {31'd0, fault}, 32'd1);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("mto_clr_fault", {31'd0, fault}, 32'd0);
      chk("mto_clr_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("mto_no_done", done_cnt - d0, 32'd0);

      // Ack timeout: eject pulse plus 15 waiting cycles, then fault
      auto_ack = 1'b0;
      send(2'b01, 6'd5);
      n = 0;
      while (!fault && n < 40) begin
         tick();
         n++;
      end
      chk("ato_cycles", n, 32'd16);
      chk("ato_eject_off", {31'd0, coin_eject}, 32'd0);
      fault_clr = 1'b1;
      tick();
      fault_clr = 1'b0;
      chk("ato_clr_state", {29'd0, dbg_state}, 32'd0);
      auto_ack = 1'b1;
      tick();

      // Op 11 amount 15, reset during 2nd EJECT_WAIT
      e0 = eject_cnt;
      send(2'b11, 6'd15);
      run_motor(2);
      n = 0;
      while ((eject_cnt - e0) < 2 && n < 40) begin
         tick();
         n++;
      end
      chk("mid_in_eject_wait", {29'd0, dbg_state}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_motor", {31'd0, motor_go}, 32'd0);
      chk("mid_rst_eject", {31'd0, coin_eject}, 32'd0);
      chk("mid_rst_done", {31'd0, done_pulse}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
      chk("mid_idle_after", {29'd0, dbg_state}, 32'd0);
      send(2'b10, 6'd0);
      run_motor(3);
      chk("post_rst_vend_done", {31'd0, done_pulse}, 32'd1);
      tick();

      // Two more vends and a refund since reset: three vends in total
      send(2'b11, 6'd0);
      run_motor(2);
      chk("vc0_done", {31'd0, done_pulse}, 32'd1);
      tick();
      send(2'b01, 6'd5);
      wait_done("cnt_refund_done", 40);
      tick();
      send(2'b10, 6'd0);
      run_motor(1);
      tick();
`ifdef VEND_COUNT_EN
      chk("vend_count", {16'd0, vend_count}, 32'd3);
`endif
      chk("final_idle", {31'd0, req_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
